nes_joypad_port: RTL
====================

# nes_joypad_port

Per-port NES controller serial interface with turbo generation. It sits directly downstream of the SNES/DualShock controller decoders, which supply 12-bit SNES-layout button words. It feeds the NES core's $4016/$4017 read path with the standard 8-bit latch/shift protocol. One instance is used per player, replacing ad-hoc shift logic and the free-floating auto-fire signals in the top level.

## Interface
- TURBO_DIV, 715909: clk cycles per turbo half-period; 15 Hz full rate at 21.477 MHz. Must be ≥ 2.
- SOCD_CLEAN, 1: when 1, opposing directions pressed together (U+D, L+R) are both reported released.

- clk  in  1  main 21.477 MHz core clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- btns  in  12  buttons, active-high, SNES layout {R L X A RT LT DN UP START SELECT Y B}.
  - Bits [7:0] are NES order: 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
  - Bit 8 is turbo-A and bit 9 is turbo-B.
- turbo_en  in  1  enables turbo injection; 0 ignores btns[9:8].
- strobe  in  1  level from CPU $4016 bit 0 (joypad_out[0]).
- joy_clk  in  1  per-port read clock from the NES core; a read completes on its falling edge.
- data_out  out  1  serial bit presented to the CPU (joypad data[0]).
- turbo_phase  out  1  current turbo square-wave phase (debug/LED).
- read_cnt  out  4  shifts since last load, saturating at 8.

## Operation
- Effective byte `eff`:
  - Start from btns[7:0].
  - If turbo_en: OR `btns[8] & turbo_phase` into bit 0 and `btns[9] & turbo_phase` into bit 1.
  - If SOCD_CLEAN: clear bits 4 and 5 when both are set; clear bits 6 and 7 when both are set. Cleaning is applied after turbo OR.
- Turbo generator:
  - Counter `tcnt`, width clog2(TURBO_DIV).
  - If turbo_en=0, or btns[9:8]==0: tcnt←0, turbo_phase←1. A fresh press is therefore active immediately.
  - Otherwise tcnt increments each cycle. At tcnt==TURBO_DIV-1: tcnt←0 and turbo_phase toggles.
- Edge detect: register `jc_q`←joy_clk every cycle. A falling edge is `jc_q & ~joy_clk`.
- Shift register `sreg[7:0]`, priority from highest to lowest:
  1. strobe=1: sreg←eff, read_cnt←0. This reloads every cycle while strobe is high, so the last value before strobe falls is held.
  2. strobe=0 and falling edge: sreg←{1'b1, sreg[7:1]}, read_cnt←min(read_cnt+1, 8).
  3. Else: hold.
- A falling edge while strobe=1 is ignored; load wins.
- data_out is sreg[0], combinational from the register. After 8 shifts it reads 1 indefinitely, matching a stock NES pad.
- btns changes while strobe=0 do not affect sreg until the next strobe.
- Reset values:
  - sreg=8'h00, so data_out=0.
  - read_cnt=0, tcnt=0, turbo_phase=1, jc_q=0.
- Reset mid-read or mid-turbo aborts immediately; the next cycle restarts from the reset values.

## Timing
- Load: strobe high at cycle N gives data_out = eff(N)[0] at cycle N+1.
- Shift: joy_clk is low at cycle N after being high at N-1. sreg shifts at the N edge, so data_out shows the next bit at N+1. Latency is one cycle from the joy_clk fall.
- joy_clk must stay low and high for ≥1 clk each; narrower pulses may be missed, with no recovery required.
- Turbo period: 2·TURBO_DIV cycles with exactly 50% duty. The toggle takes effect on the cycle after tcnt==TURBO_DIV-1.
- Releasing both turbo buttons forces turbo_phase=1 on the next cycle.
- No stalls or backpressure. All outputs are valid every cycle after reset deasserts.

## Test plan
- Reset, then idle: data_out=0, read_cnt=0, turbo_phase=1. Pulse strobe with btns=12'h000, then 10 joy_clk falls → data_out reads 0 ×8 then 1,1; read_cnt holds at 8.
- btns=12'h009 (A+Start), strobe 1→0, 8 falls → serial sequence 1,0,0,1,0,0,0,0, then a 9th read returns 1.
- SOCD_CLEAN=1, btns=12'h0F0 → all four direction bits read 0. SOCD_CLEAN=0 → bits 4–7 read 1.
- TURBO_DIV=4, turbo_en=1, btns=12'h100 held → turbo_phase shows 1 for 4 cycles, 0 for 4, repeating. Strobe at a phase-0 cycle → bit0 reads 0; at a phase-1 cycle → reads 1. With turbo_en=0 → bit0 always 0.
- Strobe held high while 3 joy_clk falls occur, btns=12'h001 → no shifts, read_cnt=0, data_out=1 throughout.
- Assert reset after 3 shifts → next cycle data_out=0, read_cnt=0, turbo_phase=1. A new strobe reloads correctly.

Source files
------------

// File: rtl/nes_joypad_port.sv
// NES controller port: latch/shift serial reader with turbo A/B
// and optional SOCD cleaning of opposing directions.
module nes_joypad_port #(
    parameter int TURBO_DIV  = 715909,
    parameter bit SOCD_CLEAN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] btns,
    input  logic        turbo_en,
    input  logic        strobe,
    input  logic        joy_clk,
    output logic        data_out,
    output logic        turbo_phase,
    output logic [3:0]  read_cnt
);

    localparam int TW = $clog2(TURBO_DIV);
    localparam logic [TW-1:0] TLAST = TW'(TURBO_DIV - 1);

    logic [TW-1:0] tcnt;
    logic [7:0]    eff;
    logic [7:0]    sreg;
    logic          jc_q;
    logic          jc_fall;
    logic          turbo_idle;

    assign turbo_idle = ~turbo_en | (btns[9:8] == 2'b00);
    assign jc_fall    = jc_q & ~joy_clk;
    assign data_out   = sreg[0];

    // Effective pad byte: raw buttons, turbo injection, then SOCD cleaning
    always_comb begin
        eff = btns[7:0];
        if (turbo_en) begin
            eff[0] = eff[0] | (btns[8] & turbo_phase);
            eff[1] = eff[1] | (btns[9] & turbo_phase);
        end
        if (SOCD_CLEAN) begin
            if (eff[4] & eff[5]) begin
                eff[4] = 1'b0;
                eff[5] = 1'b0;
            end
            if (eff[6] & eff[7]) begin
                eff[6] = 1'b0;
                eff[7] = 1'b0;
            end
        end
    end

    // Turbo square wave; idles high so a fresh press fires at once
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt        <= '0;
            turbo_phase <= 1'b1;
        end else if (turbo_idle) begin
            tcnt        <= '0;
            turbo_phase <= 1'b1;
        end else if (tcnt == TLAST) begin
            tcnt        <= '0;
            turbo_phase <= ~turbo_phase;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // Register joy_clk for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            jc_q <= 1'b0;
        end else begin
            jc_q <= joy_clk;
        end
    end

    // Latch while strobe is high, otherwise shift on joy_clk falls
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg     <= 8'h00;
            read_cnt <= 4'd0;
        end else if (strobe) begin
            sreg     <= eff;
            read_cnt <= 4'd0;
        end else if (jc_fall) begin
            sreg <= {1'b1, sreg[7:1]};
            if (read_cnt != 4'd8) begin
                read_cnt <= read_cnt + 4'd1;
            end
        end
    end

endmodule
